// File: rtl/rv32_pkg.sv
// RV32I format codes, opcodes and the nop word shared by the encoder and the decoders.
package rv32_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } enc_state_e;

    localparam logic [6:0] OP_R   = 7'h33;
    localparam logic [6:0] OP_I   = 7'h13;
    localparam logic [6:0] OP_LD  = 7'h03;
    localparam logic [6:0] OP_S   = 7'h23;
    localparam logic [6:0] OP_B   = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;
    localparam logic [6:0] OP_LUI = 7'h37;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO holding encoded words between acceptance and the imem write port.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // A pop frees the slot in the same edge, so push on full is allowed alongside it.
    assign wr_en = push & (~full | pop);
    assign rd_en = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs RV32I descriptors into instruction words and streams them to imem at consecutive addresses.
//   state   | meaning
//   IDLE    | waiting for start; len and base address captured on start
//   LOAD    | accepting descriptors and writing encoded words until written == len
//   DONE    | one-cycle session-end pulse, then back to IDLE
module instr_encoder
    import rv32_pkg::*;
#(
    parameter int          ADDR_W    = 8,
    parameter int          DEPTH     = 4,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        op,
    input  logic [2:0]        f3,
    input  logic              f7,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [31:0]       imm,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

    enc_state_e      state;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] accepted;
    logic [ADDR_W:0] written;
    logic [31:0]     enc_word;
    logic            illegal;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;

    assign in_ready = (state == ST_LOAD) & ~fifo_full & (accepted < len_q);
    assign push     = in_valid & in_ready;
    assign mem_we   = (state == ST_LOAD) & ~fifo_empty;
    assign pop      = mem_we & mem_ready;
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);

    always_comb begin
        enc_word = NOP_WORD;
        illegal  = 1'b0;
        case (fmt)
            FMT_R:   enc_word = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, op};
            FMT_I:   enc_word = {imm[11:0], rs1, f3, rd, op};
            FMT_S:   enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            FMT_B:   enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            FMT_U:   enc_word = {imm[31:12], rd, op};
            FMT_J:   enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            default: illegal  = 1'b1;
        endcase
    end

    enc_fifo #(
        .DEPTH (DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (enc_word),
        .pop   (pop),
        .rdata (mem_wdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            len_q    <= '0;
            accepted <= '0;
            written  <= '0;
            mem_addr <= BASE;
            err      <= 1'b0;
        end else begin
            if (push) begin
                accepted <= accepted + (ADDR_W+1)'(1);
                if (illegal) err <= 1'b1;
            end
            if (pop) begin
                written  <= written + (ADDR_W+1)'(1);
                mem_addr <= mem_addr + ADDR_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q    <= len;
                        accepted <= '0;
                        written  <= '0;
                        mem_addr <= BASE;
                        err      <= 1'b0;
                        state    <= (len == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (written == len_q) state <= ST_DONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: expected words queued at acceptance, checked at each imem write.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [8:0]  len = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  fmt = '0;
    logic [6:0]  op = '0;
    logic [2:0]  f3 = '0;
    logic        f7 = 1'b0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        mem_we;
    logic        mem_ready = 1'b1;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy, done, err;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    logic [31:0] wr_log [256];
    logic [7:0]  push_addr = '0;
    int cyc = 0, wr_cnt = 0, done_cnt = 0, acc_cnt = 0;
    int first_wr_cyc = 0, last_wr_cyc = 0;

    instr_encoder #(.ADDR_W(8), .DEPTH(4), .BASE_ADDR(0)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .f3(f3), .f7(f7), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
        .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] model(input logic [2:0] fm, input logic [6:0] o,
                                          input logic [2:0] ff3, input logic ff7,
                                          input logic [4:0] d, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [31:0] im);
        logic [31:0] w;
        w = 32'h0;
        w[6:0] = o;
        case (fm)
            3'd0: begin w[11:7] = d; w[14:12] = ff3; w[19:15] = s1; w[24:20] = s2; w[30] = ff7; end
            3'd1: begin w[11:7] = d; w[14:12] = ff3; w[19:15] = s1; w[31:20] = im[11:0]; end
            3'd2: begin w[11:7] = im[4:0]; w[14:12] = ff3; w[19:15] = s1; w[24:20] = s2; w[31:25] = im[11:5]; end
            3'd3: begin
                w[7] = im[11]; w[11:8] = im[4:1]; w[14:12] = ff3; w[19:15] = s1;
                w[24:20] = s2; w[30:25] = im[10:5]; w[31] = im[12];
            end
            3'd4: begin w[11:7] = d; w[31:12] = im[31:12]; end
            3'd5: begin
                w[11:7] = d; w[19:12] = im[19:12]; w[20] = im[11];
                w[30:21] = im[10:1]; w[31] = im[20];
            end
            default: w = 32'h0000_0013;
        endcase
        return w;
    endfunction

    // Monitor: pop-and-compare on writes, push the model word on acceptance.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            push_addr = 8'd0;
        end else begin
            if (mem_we && mem_ready) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write addr=%0d data=%08h required=no write", mem_addr, mem_wdata);
                end else begin
                    e = sb.pop_front();
                    if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                        fails++;
                        $display("FAIL sb_write got addr=%0d data=%08h required addr=%0d data=%08h",
                                 mem_addr, mem_wdata, e.addr, e.data);
                    end
                end
                wr_log[mem_addr] = mem_wdata;
                if (wr_cnt == 0) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                wr_cnt++;
            end
            if (done) done_cnt++;
            if (start && !busy) push_addr = 8'd0;
            if (in_valid && in_ready) begin
                e.addr = push_addr;
                e.data = model(fmt, op, f3, f7, rd, rs1, rs2, imm);
                sb.push_back(e);
                push_addr++;
                acc_cnt++;
            end
        end
    end

    task automatic clear_stats();
        wr_cnt = 0; done_cnt = 0; acc_cnt = 0;
    endtask

    task automatic start_session(input logic [8:0] l);
        start = 1'b1; len = l;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Presents one descriptor and returns #1 after the edge that accepted it; in_valid stays high.
    task automatic send(input logic [2:0] fm, input logic [6:0] o, input logic [2:0] ff3,
                        input logic ff7, input logic [4:0] d, input logic [4:0] s1,
                        input logic [4:0] s2, input logic [31:0] im);
        int n;
        fmt = fm; op = o; f3 = ff3; f7 = ff7; rd = d; rs1 = s1; rs2 = s2; imm = im;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL send_timeout in_ready=%0b required=1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin @(negedge clk); n++; end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s done_timeout done=%0b required=1", name, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({in_ready, mem_we, busy, done, err} !== 5'b0 || mem_addr !== 8'd0) begin
            fails++;
            $display("FAIL reset_state got rdy/we/busy/done/err=%05b addr=%0d required 00000 addr=0",
                     {in_ready, mem_we, busy, done, err}, mem_addr);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        clear_stats();
        mem_ready = 1'b1;
        start_session(9'd3);
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
        in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'h0050_0093 || mem_addr !== 8'd0) begin
            fails++;
            $display("FAIL basic_latency got we=%0b data=%08h addr=%0d required we=1 data=00500093 addr=0",
                     mem_we, mem_wdata, mem_addr);
        end
        @(posedge clk); #1;
        send(3'd0, 7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
        send(3'd3, 7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8);
        in_valid = 1'b0;
        wait_done("basic");
        repeat (3) @(negedge clk);
        tests++;
        if (wr_log[0] !== 32'h0050_0093 || wr_log[1] !== 32'h4020_81B3 || wr_log[2] !== 32'hFE20_8CE3) begin
            fails++;
            $display("FAIL basic_words got %08h %08h %08h required 00500093 402081B3 FE208CE3",
                     wr_log[0], wr_log[1], wr_log[2]);
        end
        tests++;
        if (done_cnt != 1 || busy !== 1'b0 || mem_addr !== 8'd3 || wr_cnt != 3) begin
            fails++;
            $display("FAIL basic_end got done_cnt=%0d busy=%0b addr=%0d writes=%0d required 1 0 3 3",
                     done_cnt, busy, mem_addr, wr_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_s_j();
        clear_stats();
        start_session(9'd2);
        send(3'd2, 7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8);
        send(3'd5, 7'h6F, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16);
        in_valid = 1'b0;
        wait_done("s_j");
        tests++;
        if (wr_log[0] !== 32'h0020_A423 || wr_log[1] !== 32'h0100_00EF || wr_cnt != 2) begin
            fails++;
            $display("FAIL s_j_words got %08h %08h writes=%0d required 0020A423 010000EF 2",
                     wr_log[0], wr_log[1], wr_cnt);
        end
    endtask

    task automatic test_backpressure();
        clear_stats();
        mem_ready = 1'b0;
        start_session(9'd8);
        for (int i = 0; i < 4; i++)
            send(3'd1, 7'h13, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
        fmt = 3'd1; rd = 5'd5; imm = 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b0 || mem_we !== 1'b1 || mem_wdata !== 32'h0000_0093 ||
                mem_addr !== 8'd0 || acc_cnt != 4) begin
                fails++;
                $display("FAIL bp_stall got rdy=%0b we=%0b data=%08h addr=%0d acc=%0d required 0 1 00000093 0 4",
                         in_ready, mem_we, mem_wdata, mem_addr, acc_cnt);
            end
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        for (int i = 4; i < 8; i++)
            send(3'd1, 7'h13, 3'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i));
        in_valid = 1'b0;
        wait_done("bp");
        tests++;
        if (wr_cnt != 8 || mem_addr !== 8'd8 || done_cnt != 1 || wr_log[7] !== 32'h0070_0413) begin
            fails++;
            $display("FAIL bp_end got writes=%0d addr=%0d done_cnt=%0d w7=%08h required 8 8 1 00700413",
                     wr_cnt, mem_addr, done_cnt, wr_log[7]);
        end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        start_session(9'd6);
        for (int i = 0; i < 6; i++)
            send(3'($urandom_range(0, 5)), 7'($urandom), 3'($urandom), 1'($urandom),
                 5'($urandom), 5'($urandom), 5'($urandom), $urandom);
        in_valid = 1'b0;
        wait_done("b2b");
        tests++;
        if (wr_cnt != 6 || (last_wr_cyc - first_wr_cyc) != 5) begin
            fails++;
            $display("FAIL b2b_throughput got writes=%0d span=%0d required 6 5",
                     wr_cnt, last_wr_cyc - first_wr_cyc);
        end
    endtask

    task automatic test_illegal();
        clear_stats();
        start_session(9'd1);
        send(3'd7, 7'h33, 3'd1, 1'b1, 5'd9, 5'd9, 5'd9, 32'hFFFF_FFFF);
        in_valid = 1'b0;
        wait_done("illegal");
        repeat (3) @(negedge clk);
        tests++;
        if (wr_log[0] !== 32'h0000_0013 || err !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL illegal_nop got word=%08h err=%0b busy=%0b required 00000013 1 0",
                     wr_log[0], err, busy);
        end
        @(posedge clk); #1;
        clear_stats();
        start_session(9'd0);
        @(negedge clk);
        tests++;
        if (err !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL len0_pulse got err=%0b done=%0b required err=0 done=1", err, done);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (done_cnt != 1 || wr_cnt != 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL len0_end got done_cnt=%0d writes=%0d busy=%0b required 1 0 0",
                     done_cnt, wr_cnt, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored();
        clear_stats();
        start_session(9'd2);
        send(3'd4, 7'h37, 3'd0, 1'b0, 5'd7, 5'd0, 5'd0, 32'h1234_5000);
        in_valid = 1'b0;
        start_session(9'd5);
        send(3'd1, 7'h03, 3'd2, 1'b0, 5'd4, 5'd2, 5'd0, 32'hFFFF_FFFC);
        in_valid = 1'b0;
        wait_done("start_ign");
        repeat (2) @(negedge clk);
        tests++;
        if (wr_cnt != 2 || mem_addr !== 8'd2 || done_cnt != 1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL start_ignored got writes=%0d addr=%0d done_cnt=%0d busy=%0b required 2 2 1 0",
                     wr_cnt, mem_addr, done_cnt, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid();
        int n;
        clear_stats();
        mem_ready = 1'b1;
        start_session(9'd5);
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1);
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2);
        in_valid = 1'b0;
        n = 0;
        while (wr_cnt < 2 && n < 50) begin @(negedge clk); n++; end
        tests++;
        if (wr_cnt < 2) begin
            fails++;
            $display("FAIL rst_mid_writes got %0d required 2", wr_cnt);
        end
        @(posedge clk); #1;
        mem_ready = 1'b0;
        send(3'd1, 7'h13, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        tests++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 8'd0) begin
            fails++;
            $display("FAIL rst_mid_flush got we=%0b busy=%0b addr=%0d required 0 0 0", mem_we, busy, mem_addr);
        end
        repeat (5) @(negedge clk);
        tests++;
        if (done_cnt != 0 || wr_cnt != 2) begin
            fails++;
            $display("FAIL rst_mid_quiet got done_cnt=%0d writes=%0d required 0 2", done_cnt, wr_cnt);
        end
        @(posedge clk); #1;
        clear_stats();
        start_session(9'd1);
        send(3'd0, 7'h33, 3'd7, 1'b0, 5'd10, 5'd11, 5'd12, 32'd0);
        in_valid = 1'b0;
        wait_done("rst_restart");
        tests++;
        if (wr_cnt != 1 || mem_addr !== 8'd1 || wr_log[0] !== 32'h00C5_F533) begin
            fails++;
            $display("FAIL rst_restart got writes=%0d addr=%0d w0=%08h required 1 1 00C5F533",
                     wr_cnt, mem_addr, wr_log[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_s_j();
        test_backpressure();
        test_back_to_back();
        test_illegal();
        test_start_ignored();
        test_rst_mid();
        repeat (3) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain got %0d pending required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
